axi4_lite_reg_sub: RTL and testbench

AXI4_LITE_REG_SUB -- requirements
Module: axi4_lite_reg_sub

---
 rtl/axi4_lite_reg_sub.sv | 139 +++++++++++++
 tb/tb_axi4_lite_reg_sub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_sub.sv
// AXI4-Lite register bank: NUM_REGS word registers behind independent write and read FSMs,
// with a flat register view and a one-hot write strobe for downstream logic.
module axi4_lite_reg_sub #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           awvalid,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  output logic                           awready,
  input  logic                           wvalid,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           wready,
  output logic                           bvalid,
  output logic [2:0]                     bresp,
  input  logic                           bready,
  input  logic                           arvalid,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           arready,
  output logic                           rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic {W_IDLE, W_RESP} wState_e;
  typedef enum logic {R_IDLE, R_DATA} rState_e;

  function automatic logic addrOk(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (2 + IDX_W)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] idxOf(input logic [ADDR_WIDTH-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  wState_e                 wState_q, wState_d;
  rState_e                 rState_q, rState_d;
  logic                    live_q;
  logic                    awCap_q, awCap_d;
  logic                    wCap_q, wCap_d;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [2:0]              bresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [NUM_REGS-1:0]     wrPulse_q, wrPulse_d;
  logic [DATA_WIDTH-1:0]   regFile_q [NUM_REGS];

  logic                    awHs, wHs, arHs, commit, wrOk;
  logic [ADDR_WIDTH-1:0]   curAddr;
  logic [DATA_WIDTH-1:0]   curData;
  logic [IDX_W-1:0]        wrIdx;

  // Readies stay low until the first clock edge after reset release (live_q).
  assign awready = live_q && (wState_q == W_IDLE) && !awCap_q;
  assign wready  = live_q && (wState_q == W_IDLE) && !wCap_q;
  assign arready = live_q && (rState_q == R_IDLE);
  assign bvalid  = (wState_q == W_RESP);
  assign rvalid  = (rState_q == R_DATA);
  assign bresp   = bresp_q;
  assign rdata   = rdata_q;
  assign wr_pulse = wrPulse_q;

  assign awHs = awvalid && awready;
  assign wHs  = wvalid && wready;
  assign arHs = arvalid && arready;

  assign curAddr = awCap_q ? awAddr_q : awaddr;
  assign curData = wCap_q ? wData_q : wdata;
  assign commit  = (wState_q == W_IDLE) && (awCap_q || awHs) && (wCap_q || wHs);
  assign wrOk    = addrOk(curAddr);
  assign wrIdx   = idxOf(curAddr);

  for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
    assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regFile_q[g];
  end

  always_comb begin
    wState_d  = wState_q;
    rState_d  = rState_q;
    awCap_d   = awCap_q || awHs;
    wCap_d    = wCap_q || wHs;
    wrPulse_d = '0;
    case (wState_q)
      W_IDLE: begin
        if (commit) begin
          wState_d = W_RESP;
          awCap_d  = 1'b0;
          wCap_d   = 1'b0;
          if (wrOk) wrPulse_d[wrIdx] = 1'b1;
        end
      end
      W_RESP:  if (bready) wState_d = W_IDLE;
      default: wState_d = W_IDLE;
    endcase
    case (rState_q)
      R_IDLE:  if (arHs) rState_d = R_DATA;
      R_DATA:  if (rready) rState_d = R_IDLE;
      default: rState_d = R_IDLE;
    endcase
  end

  // A read sampling on the commit edge sees the pre-write value via non-blocking semantics.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wState_q  <= W_IDLE;
      rState_q  <= R_IDLE;
      live_q    <= 1'b0;
      awCap_q   <= 1'b0;
      wCap_q    <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      bresp_q   <= 3'b000;
      rdata_q   <= '0;
      wrPulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regFile_q[i] <= '0;
    end else begin
      wState_q  <= wState_d;
      rState_q  <= rState_d;
      live_q    <= 1'b1;
      awCap_q   <= awCap_d;
      wCap_q    <= wCap_d;
      wrPulse_q <= wrPulse_d;
      if (awHs) awAddr_q <= awaddr;
      if (wHs)  wData_q  <= wdata;
      if (commit) begin
        bresp_q <= wrOk ? 3'b000 : 3'b010;
        if (wrOk) regFile_q[wrIdx] <= curData;
      end
      if (arHs) rdata_q <= addrOk(araddr) ? regFile_q[idxOf(araddr)] : '0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_sub.sv
// Self-checking bench for axi4_lite_reg_sub: directed scenarios plus random single
// transactions compared against an array-based register model.
module tb_axi4_lite_reg_sub;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  typedef logic [NR*DW-1:0] wide_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [2:0]    bresp;
  logic [DW-1:0] rdata;
  wide_t         regs_q;
  logic [NR-1:0] wr_pulse;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [NR];

  always #5 aclk = ~aclk;

  axi4_lite_reg_sub #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .regs_q(regs_q), .wr_pulse(wr_pulse)
  );

  task automatic checkOutput(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wide_t flat();
    wide_t f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  // Reference decode: word-aligned and inside the 4*NR byte window.
  function automatic bit addrValid(input logic [AW-1:0] a);
    return (a % 4 == 0) && (a < 4 * NR);
  endfunction

  function automatic int idxModel(input logic [AW-1:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic logic [NR-1:0] pulseFor(input logic [AW-1:0] a);
    logic [NR-1:0] p;
    p = '0;
    if (addrValid(a)) p[idxModel(a)] = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic awv, input logic [AW-1:0] awa, input logic wv,
                               input logic [DW-1:0] wd, input logic arv, input logic [AW-1:0] ara);
    awvalid = awv; awaddr = awa; wvalid = wv; wdata = wd; arvalid = arv; araddr = ara;
  endtask

  task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int hold);
    checkOutput("awready_idle", wide_t'(awready), wide_t'(1'b1));
    applyStimulus(1'b1, addr, 1'b1, data, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    if (addrValid(addr)) model[idxModel(addr)] = data;
    checkOutput("bvalid_set", wide_t'(bvalid), wide_t'(1'b1));
    checkOutput("bresp", wide_t'(bresp), wide_t'(addrValid(addr) ? 3'b000 : 3'b010));
    checkOutput("wr_pulse", wide_t'(wr_pulse), wide_t'(pulseFor(addr)));
    checkOutput("regs_after_write", regs_q, flat());
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("bvalid_hold", wide_t'(bvalid), wide_t'(1'b1));
      checkOutput("wr_pulse_clear", wide_t'(wr_pulse), '0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("bvalid_drop", wide_t'(bvalid), wide_t'(1'b0));
  endtask

  task automatic readTxn(input logic [AW-1:0] addr, input int hold);
    logic [DW-1:0] exp;
    exp = addrValid(addr) ? model[idxModel(addr)] : '0;
    checkOutput("arready_idle", wide_t'(arready), wide_t'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, addr);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    checkOutput("rvalid_set", wide_t'(rvalid), wide_t'(1'b1));
    checkOutput("rdata", wide_t'(rdata), wide_t'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("rdata_hold", wide_t'(rdata), wide_t'(exp));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput("rvalid_drop", wide_t'(rvalid), wide_t'(1'b0));
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int r;
    for (int i = 0; i < NR; i++) model[i] = '0;

    #1;
    checkOutput("rst_regs", regs_q, '0);
    checkOutput("rst_ready", wide_t'({awready, wready, arready}), '0);
    checkOutput("rst_valid", wide_t'({bvalid, rvalid, bresp}), '0);
    checkOutput("rst_pulse_rdata", wide_t'({wr_pulse, rdata}), '0);
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    tick();
    checkOutput("ready_after_rst", wide_t'({awready, wready, arready}), wide_t'(3'b111));

    writeTxn(32'h8, 32'hDEADBEEF, 0);
    checkOutput("reg2_value", wide_t'(regs_q[2*DW +: DW]), wide_t'(32'hDEADBEEF));

    // W arrives three cycles ahead of AW; stray valids during the response are ignored.
    applyStimulus(1'b0, '0, 1'b1, 32'h1234, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("early_w_wready", wide_t'(wready), wide_t'(1'b0));
      checkOutput("early_w_awready", wide_t'(awready), wide_t'(1'b1));
      checkOutput("early_w_nowrite", regs_q, flat());
      checkOutput("early_w_nob", wide_t'({bvalid, wr_pulse}), '0);
      if (i < 2) tick();
    end
    applyStimulus(1'b1, 32'h4, 1'b0, '0, 1'b0, '0);
    tick();
    model[1] = 32'h1234;
    checkOutput("late_aw_bvalid", wide_t'(bvalid), wide_t'(1'b1));
    checkOutput("late_aw_pulse", wide_t'(wr_pulse), wide_t'(16'h0002));
    checkOutput("late_aw_regs", regs_q, flat());
    applyStimulus(1'b1, 32'h10, 1'b1, 32'hBAD, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_bvalid", wide_t'(bvalid), wide_t'(1'b1));
      checkOutput("hold_bresp", wide_t'(bresp), wide_t'(3'b000));
      checkOutput("hold_ready_low", wide_t'({awready, wready}), '0);
      checkOutput("hold_noside", regs_q, flat());
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("release_b", wide_t'({bvalid, awready, wready}), wide_t'(3'b011));
    checkOutput("release_regs", regs_q, flat());

    writeTxn(32'h100, 32'hCAFEF00D, 1);
    readTxn(32'h2, 0);
    readTxn(32'h8000_0008, 0);
    checkOutput("bad_addr_regs", regs_q, flat());

    // Write commit and read sample on the same edge and register.
    writeTxn(32'hC, 32'h11, 0);
    applyStimulus(1'b1, 32'hC, 1'b1, 32'h22, 1'b1, 32'hC);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    model[3] = 32'h22;
    checkOutput("same_edge_rdata", wide_t'(rdata), wide_t'(32'h11));
    checkOutput("same_edge_valids", wide_t'({bvalid, rvalid}), wide_t'(2'b11));
    checkOutput("same_edge_pulse", wide_t'(wr_pulse), wide_t'(16'h0008));
    checkOutput("same_edge_regs", regs_q, flat());
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    checkOutput("same_edge_done", wide_t'({bvalid, rvalid}), '0);
    readTxn(32'hC, 0);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = AW'($urandom_range(0, NR - 1) * 4);
      else if (r == 7) addr = AW'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
      else             addr = AW'(4 * NR + $urandom_range(0, 255) * 4);
      data = $urandom;
      if ($urandom_range(0, 1) == 1) writeTxn(addr, data, int'($urandom_range(0, 2)));
      else                           readTxn(addr, int'($urandom_range(0, 2)));
    end
    checkOutput("random_regs", regs_q, flat());

    // Reset while a read response is stalled.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    checkOutput("pre_rst_rvalid", wide_t'(rvalid), wide_t'(1'b1));
    #2 areset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    checkOutput("mid_rst_rvalid", wide_t'(rvalid), wide_t'(1'b0));
    checkOutput("mid_rst_regs", regs_q, flat());
    checkOutput("mid_rst_ready", wide_t'({awready, wready, arready}), '0);
    @(posedge aclk);
    #2 areset = 1'b0;
    tick();
    checkOutput("post_rst_ready", wide_t'({awready, wready, arready}), wide_t'(3'b111));
    readTxn(32'h8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
